// File: rtl/u74hc595_sim.sv
// u74hc595_sim -- tick-based model of a 74HC595 serial-in shift register with
// an output storage latch and 3-state outputs.
//
// Chip pins (srclk, rclk, ...) are plain data inputs sampled on clk. Every
// register update reaches the pins `delay` ticks later through a pipeline.
//
// Parameters
//   delay : ticks from a register update to the pin change (1..32)
//   ic    : reset contents of the shift and storage registers (bit 0 = QA)
// Ports
//   clk      : global simulation tick, rising edge
//   rst      : asynchronous active-high reset
//   vcc      : supply pin, 0 = unpowered (acts as a held reset)
//   gnd      : ground pin, no function
//   ser      : serial data in
//   srclk    : shift clock pin
//   rclk     : storage latch clock pin
//   srclr_n  : shift register clear, active low
//   oe_n     : output enable, active low
//   q        : QA..QH on q[0]..q[7], 3-state
//   qh_prime : serial out QH', always driven
module u74hc595_sim #(
  parameter int         delay = 9,
  parameter logic [7:0] ic    = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vcc,
  input  logic       gnd,
  input  logic       ser,
  input  logic       srclk,
  input  logic       rclk,
  input  logic       srclr_n,
  input  logic       oe_n,
  output logic [7:0] q,
  output logic       qh_prime
);

  typedef struct packed {
    logic [7:0] st;
    logic       sr7;
    logic       oe;
  } pipe_t;

  localparam pipe_t PIPE_RST = '{st: ic, sr7: ic[7], oe: 1'b1};

  // Ground carries no function in this model.
  logic unused_gnd;
  assign unused_gnd = gnd;

  // Previous-sample registers. The clock pins double as edge-detect history;
  // the others hold the last known level so an X/Z pin reads as unchanged.
  logic       srclk_q, rclk_q, ser_q, srclr_n_q, oe_n_q;
  logic [7:0] sr_q, st_q;
  pipe_t      pipe_q [delay];

  logic       srclk_s, rclk_s, ser_s, srclr_n_s, oe_n_s;
  logic       sr_edge, st_edge;
  logic [7:0] sr_d, st_d;

  function automatic logic sample(input logic pin, input logic held);
    if (pin === 1'b1)      return 1'b1;
    else if (pin === 1'b0) return 1'b0;
    else                   return held;
  endfunction

  always_comb begin
    srclk_s   = sample(srclk, srclk_q);
    rclk_s    = sample(rclk, rclk_q);
    ser_s     = sample(ser, ser_q);
    srclr_n_s = sample(srclr_n, srclr_n_q);
    oe_n_s    = sample(oe_n, oe_n_q);

    sr_edge = srclk_s & ~srclk_q;
    st_edge = rclk_s & ~rclk_q;

    // Clear beats shift; the latch always sees the start-of-tick sr, so a
    // simultaneous shift or clear leaves storage one step behind.
    sr_d = sr_q;
    if (!srclr_n_s)   sr_d = 8'h00;
    else if (sr_edge) sr_d = {sr_q[6:0], ser_s};

    st_d = st_edge ? sr_q : st_q;
  end

  always_ff @(posedge clk or posedge rst or negedge vcc) begin
    if (rst || !vcc) begin
      // Clock history resets high so a pin held high at release is no edge.
      srclk_q   <= 1'b1;
      rclk_q    <= 1'b1;
      ser_q     <= 1'b0;
      srclr_n_q <= 1'b1;
      oe_n_q    <= 1'b0;
      sr_q      <= ic;
      st_q      <= ic;
      for (int i = 0; i < delay; i++) pipe_q[i] <= PIPE_RST;
    end else begin
      srclk_q   <= srclk_s;
      rclk_q    <= rclk_s;
      ser_q     <= ser_s;
      srclr_n_q <= srclr_n_s;
      oe_n_q    <= oe_n_s;
      sr_q      <= sr_d;
      st_q      <= st_d;
      // Stage 0 takes the registered (post-update) state, so an update on
      // tick T reaches the last stage on tick T+delay.
      pipe_q[0] <= '{st: st_q, sr7: sr_q[7], oe: ~oe_n_q};
      for (int i = 1; i < delay; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q        = pipe_q[delay-1].oe ? pipe_q[delay-1].st : 8'bz;
  assign qh_prime = pipe_q[delay-1].sr7;

endmodule

// File: tb/tb_u74hc595_sim.sv
// Directed bench for u74hc595_sim: two instances (ic=A5 on main supply,
// ic=3C on its own vcc) share the chip pins. q nets carry pullups so a
// released (3-state) bus reads as 8'hFF.
module tb_u74hc595_sim;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vcc_a = 1'b1, vcc_b = 1'b1, gnd = 1'b0;
  logic       ser = 1'b0, srclk = 1'b0, rclk = 1'b0;
  logic       srclr_n = 1'b1, oe_n = 1'b0;
  wire  [7:0] q_a, q_b;
  logic       qh_a, qh_b;

  int n_cmp = 0;
  int n_err = 0;

  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (q_a[i]);
    pullup (q_b[i]);
  end

  u74hc595_sim #(.delay(9), .ic(8'hA5)) dut_a (
    .clk(clk), .rst(rst), .vcc(vcc_a), .gnd(gnd), .ser(ser), .srclk(srclk),
    .rclk(rclk), .srclr_n(srclr_n), .oe_n(oe_n), .q(q_a), .qh_prime(qh_a));

  u74hc595_sim #(.delay(9), .ic(8'h3C)) dut_b (
    .clk(clk), .rst(rst), .vcc(vcc_b), .gnd(gnd), .ser(ser), .srclk(srclk),
    .rclk(rclk), .srclr_n(srclr_n), .oe_n(oe_n), .q(q_b), .qh_prime(qh_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) step();
  endtask

  // One srclk rise carrying bit b.
  task automatic shift_bit(input logic b);
    ser = b; srclk = 1'b1; step();
    srclk = 1'b0; step();
  endtask

  task automatic shift_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) shift_bit(v[i]);
  endtask

  task automatic pulse_rclk();
    rclk = 1'b1; step();
    rclk = 1'b0;
  endtask

  initial begin
    // Reset
    #1 rst = 1'b1;
    #1;
    chk("rst_q_a",  q_a, 8'hA5);
    chk("rst_qh_a", {7'd0, qh_a}, 8'h01);
    chk("rst_q_b",  q_b, 8'h3C);
    wait_n(3);
    rst = 1'b0;
    wait_n(12);
    chk("post_rst_q",  q_a, 8'hA5);
    chk("post_rst_qh", {7'd0, qh_a}, 8'h01);

    // Shift CA, latch at T: old value at T+8, new at T+9
    shift_byte(8'hCA);
    pulse_rclk();
    wait_n(8);
    chk("latch_t8", q_a, 8'hA5);
    step();
    chk("latch_t9", q_a, 8'hCA);
    chk("latch_qh", {7'd0, qh_a}, 8'h01);

    // sr=01, then srclk+rclk together with ser=1: st gets pre-shift 01, sr=03
    shift_byte(8'h01);
    ser = 1'b1; srclk = 1'b1; rclk = 1'b1; step();
    srclk = 1'b0; rclk = 1'b0;
    wait_n(8);
    chk("same_t8", q_a, 8'hCA);
    step();
    chk("same_q",  q_a, 8'h01);
    chk("same_qh", {7'd0, qh_a}, 8'h00);

    // Clear with simultaneous srclk and rclk: st gets pre-clear 03, shift ignored
    ser = 1'b1; srclr_n = 1'b0; srclk = 1'b1; rclk = 1'b1; step();
    srclr_n = 1'b1; srclk = 1'b0; rclk = 1'b0;
    wait_n(9);
    chk("clr_preval", q_a, 8'h03);
    pulse_rclk();
    wait_n(9);
    chk("clr_q",  q_a, 8'h00);
    chk("clr_qh", {7'd0, qh_a}, 8'h00);

    // Output enable: disable and re-enable with 9-tick latency
    shift_byte(8'h8B);
    pulse_rclk();
    wait_n(9);
    chk("oe_pre", q_a, 8'h8B);
    oe_n = 1'b1; step();
    wait_n(8);
    chk("oe_off_t8", q_a, 8'h8B);
    step();
    chk("oe_off_q",  q_a, 8'hFF);
    chk("oe_off_qh", {7'd0, qh_a}, 8'h01);
    oe_n = 1'b0; step();
    wait_n(8);
    chk("oe_on_t8", q_a, 8'hFF);
    step();
    chk("oe_on_q", q_a, 8'h8B);

    // Power loss mid-shift on dut_b, srclk held high across restore
    shift_bit(1'b1);
    shift_bit(1'b1);
    ser = 1'b1; srclk = 1'b1; step();
    vcc_b = 1'b0;
    #1;
    chk("pwr_q",  q_b, 8'h3C);
    chk("pwr_qh", {7'd0, qh_b}, 8'h00);
    wait_n(3);
    vcc_b = 1'b1;
    wait_n(3);
    pulse_rclk();
    wait_n(9);
    chk("pwr_noshift", q_b, 8'h3C);
    srclk = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/u74hc595_sim.md
Name: u74hc595_sim

Overview:
- Tick-based model of a 74HC595 8-bit serial-in shift register with output storage latch and 3-state outputs, for the msSimulation chip library.
- Typically feeds or consumes hex-inverter stages on the same board.
- Chip pins such as SRCLK and RCLK are ordinary data inputs. They are sampled on the global simulation clock `clk`, and propagation delay is counted in `clk` ticks.
- Loss of `vcc` behaves like a held reset.

Parameters:
- delay, 9: ticks from an internal register update to the corresponding output pin change; legal range 1..32.
- ic, 8'h00: initial/reset contents of both the shift register and the storage register; bit 0 = QA.

Ports:
- clk  input  1  global simulation tick; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- vcc  input  1  supply pin; 0 = unpowered.
- gnd  input  1  ground pin; unused functionally.
- ser  input  1  serial data in (pin 14).
- srclk  input  1  shift clock pin (pin 11).
- rclk  input  1  storage latch clock pin (pin 12).
- srclr_n  input  1  shift register clear, active low (pin 10).
- oe_n  input  1  output enable, active low (pin 13).
- q  output  8  QA..QH = q[0]..q[7]; 3-state.
- qh_prime  output  1  serial out QH' (pin 9); never 3-state.

Behaviour:
- Effective reset: vrst = rst | ~vcc. It acts asynchronously on all state.
- While vrst is high:
  - sr = ic and st = ic.
  - srclk_d and rclk_d (previous-sample registers) = 1, so a pin held high at reset release gives no edge.
  - Output delay pipeline is flushed to {st=ic, sr[7]=ic[7], oe=enabled}, so q = ic and qh_prime = ic[7] immediately.
  - Inputs are ignored.
- Edge detection each tick:
  - sr_edge = srclk & ~srclk_d.
  - st_edge = rclk & ~rclk_d.
  - srclk_d and rclk_d then load the current pin values.
- Shift register, priority order per tick:
  1. srclr_n sampled 0: sr = 8'h00; any sr_edge is ignored.
  2. Otherwise, on sr_edge: sr = {sr[6:0], ser}, i.e. ser enters QA and bit 7 is discarded.
- Storage register, on st_edge: st = sr value as it stood at the start of the tick.
  - If sr_edge and st_edge occur in the same tick, st gets the pre-shift value, so storage is one stage behind (matches the real chip with RCLK tied to SRCLK).
  - If srclr_n = 0 and st_edge occur in the same tick, st gets the pre-clear value.
- Output pipeline:
  - Stage 0 = {st, sr[7], ~oe_n}, computed from post-update register values and the sampled oe_n.
  - It passes through `delay` register stages.
  - Pins drive the last stage: q = oe ? st_dly : 8'bz, and qh_prime = sr7_dly.
  - Latency: a pin edge sampled on tick T changes the output on tick T+delay, for both data and enable/disable.
- No glitching: outputs change only on clk edges.
- Inputs that are X/Z are treated as unchanged (hold the previous sampled value).
- Reset mid-operation: a pending pipeline content is discarded. After release, the first possible output change is `delay` ticks after the first accepted edge.
- vcc dropping mid-operation is identical to rst.
- Continuous shifting wraps nothing: after 8 shifts, sr holds the last 8 ser bits.

Test Plan:
- Reset with ic=8'hA5, oe_n=0 → q=8'hA5 and qh_prime=1 during reset and after release, with no change until an edge.
- Shift 8'b1100_1010 MSB-first (8 srclk pulses, ser valid before each rise), then one rclk pulse at tick T → q=8'hCA at exactly T+9, q unchanged at T+8.
- srclk and rclk pulsed in the same tick after loading 8'h01 then shifting ser=1 → q=8'h01 (pre-shift) and qh_prime reflects new sr[7].
- srclr_n=0 with a simultaneous srclk edge, then an rclk pulse → q=8'h00; the srclk edge is ignored.
- oe_n 0→1 at tick T → q=8'bzzzz_zzzz at T+9; qh_prime is still driven; oe_n back to 0 restores the prior st value after 9 ticks.
- vcc=0 for 3 ticks mid-shift with ic=8'h3C → q=8'h3C at once; srclk held high across power restore produces no shift.
